// File: rtl/chunk_sequencer.sv
// Tile address walker: visits every CHUNK_SIZE x CHUNK_SIZE tile of the matrix in row-major
// tile order and presents each tile's top-left byte address over a valid/ready handshake.
module chunk_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ARR_SIZE   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CHUNK_SIZE = 2,
    localparam int NC        = ARR_SIZE / CHUNK_SIZE,
    localparam int CW        = (NC > 1) ? $clog2(NC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  chunk_ready,
    output logic                  chunk_valid,
    output logic [ADDR_WIDTH-1:0] chunk_addr,
    output logic [CW-1:0]         chunk_row,
    output logic [CW-1:0]         chunk_col,
    output logic                  chunk_last,
    output logic                  busy,
    output logic                  done
);

    localparam int COL_STEP_INT = CHUNK_SIZE * (DATA_WIDTH / 8);
    localparam int ROW_STEP_INT = CHUNK_SIZE * ARR_SIZE * (DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] COL_STEP      = ADDR_WIDTH'(COL_STEP_INT);
    // Moving to the next tile row also rewinds the column steps taken along the previous row.
    localparam logic [ADDR_WIDTH-1:0] ROW_WRAP_STEP = ADDR_WIDTH'(ROW_STEP_INT - (NC - 1) * COL_STEP_INT);
    localparam logic [CW-1:0]         LAST_IDX      = CW'(NC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [CW-1:0]           row_reg, row_next;
    logic [CW-1:0]           col_reg, col_next;
    logic                    last_reg, last_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                    addr_next  = base_addr;
                    row_next   = '0;
                    col_next   = '0;
                    last_next  = (NC == 1);
                end
            end
            ISSUE: begin
                if (abort || (chunk_ready && last_reg)) begin
                    // Payload returns to zero so the outputs are quiet outside ISSUE.
                    state_next = abort ? IDLE : DONE;
                    addr_next  = '0;
                    row_next   = '0;
                    col_next   = '0;
                    last_next  = 1'b0;
                end else if (chunk_ready) begin
                    if (col_reg == LAST_IDX) begin
                        col_next  = '0;
                        row_next  = row_reg + CW'(1);
                        addr_next = addr_reg + ROW_WRAP_STEP;
                    end else begin
                        col_next  = col_reg + CW'(1);
                        addr_next = addr_reg + COL_STEP;
                    end
                    last_next = (row_next == LAST_IDX) && (col_next == LAST_IDX);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign chunk_valid = (state_reg == ISSUE);
    assign chunk_addr  = addr_reg;
    assign chunk_row   = row_reg;
    assign chunk_col   = col_reg;
    assign chunk_last  = last_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_chunk_sequencer.sv
// Directed bench for chunk_sequencer at default parameters (NC = 4, column step 8, row step 64).
module tb_chunk_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] base_addr;
    logic       chunk_ready;
    logic       chunk_valid;
    logic [7:0] chunk_addr;
    logic [1:0] chunk_row;
    logic [1:0] chunk_col;
    logic       chunk_last;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    chunk_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .chunk_ready (chunk_ready),
        .chunk_valid (chunk_valid),
        .chunk_addr  (chunk_addr),
        .chunk_row   (chunk_row),
        .chunk_col   (chunk_col),
        .chunk_last  (chunk_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, " valid"}, 32'(chunk_valid), 0);
        check_eq({tag, " addr"},  32'(chunk_addr), 0);
        check_eq({tag, " row"},   32'(chunk_row), 0);
        check_eq({tag, " col"},   32'(chunk_col), 0);
        check_eq({tag, " last"},  32'(chunk_last), 0);
        check_eq({tag, " busy"},  32'(busy), 0);
        check_eq({tag, " done"},  32'(done), 0);
    endtask

    // Full walk with per-tile checks; optional stall of stall_n ready-low cycles on stall_tile.
    task automatic walk(input logic [7:0] base, input bit do_start, input int stall_tile,
                        input int stall_n, input bit keep_start);
        int cycles;
        int n;
        logic [7:0] exp_addr;
        if (do_start) begin
            base_addr = base;
            start     = 1'b1;
            tick();
        end
        if (!keep_start) start = 1'b0;
        base_addr = 8'h00;
        cycles = 0;
        for (int k = 0; k < 16; k++) begin
            exp_addr = 8'(int'(base) + (k / 4) * 64 + (k % 4) * 8);
            n = (k == stall_tile) ? stall_n : 0;
            for (int s = 0; s <= n; s++) begin
                chunk_ready = (s == n);
                check_eq($sformatf("t%0d valid", k), 32'(chunk_valid), 1);
                check_eq($sformatf("t%0d addr", k),  32'(chunk_addr), 32'(exp_addr));
                check_eq($sformatf("t%0d row", k),   32'(chunk_row), 32'(k / 4));
                check_eq($sformatf("t%0d col", k),   32'(chunk_col), 32'(k % 4));
                check_eq($sformatf("t%0d last", k),  32'(chunk_last), (k == 15) ? 1 : 0);
                check_eq($sformatf("t%0d busy", k),  32'(busy), 1);
                check_eq($sformatf("t%0d done", k),  32'(done), 0);
                tick();
                cycles++;
            end
        end
        chunk_ready = 1'b1;
        check_eq("walk cycles", 32'(cycles), 32'(16 + stall_n));
        check_eq("done pulse",  32'(done), 1);
        check_eq("done valid",  32'(chunk_valid), 0);
        check_eq("done busy",   32'(busy), 1);
        tick();
        check_eq("post done",   32'(done), 0);
        check_eq("post busy",   32'(busy), 0);
        check_eq("post valid",  32'(chunk_valid), 0);
        $display("walk base=%0d stall_tile=%0d stall=%0d cycles=%0d", base, stall_tile, stall_n, cycles);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = 8'h00; chunk_ready = 1'b1;
        #12;
        check_quiet("reset");
        rst = 1'b0;
        tick();
        check_quiet("idle");

        // Plain walk, then backpressure on tile 5, then address wrap with mid-walk base change.
        walk(8'd0, 1'b1, -1, 0, 1'b0);
        walk(8'd0, 1'b1, 5, 3, 1'b0);
        walk(8'd200, 1'b1, -1, 0, 1'b0);

        // Abort coincident with the handshake of tile 3.
        base_addr = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check_eq("pre-abort addr", 32'(chunk_addr), 24);
        abort = 1'b1; chunk_ready = 1'b1;
        tick();
        abort = 1'b0;
        check_quiet("abort");
        tick();
        check_quiet("abort idle");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_quiet("abort in idle");
        $display("abort on tile 3");
        walk(8'd0, 1'b1, -1, 0, 1'b0);

        // Asynchronous reset between edges during tile 9.
        base_addr = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check_eq("pre-rst addr", 32'(chunk_addr), 136);
        #2 rst = 1'b1;
        #1;
        check_quiet("async rst");
        #1 rst = 1'b0;
        tick();
        check_quiet("after rst");
        $display("reset during tile 9");
        walk(8'd64, 1'b1, -1, 0, 1'b0);

        // start and abort together in IDLE: start wins.
        base_addr = 8'd16; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_eq("start+abort valid", 32'(chunk_valid), 1);
        walk(8'd16, 1'b0, -1, 0, 1'b0);

        // start held high through a walk: next walk accepted only from the IDLE cycle after done.
        walk(8'd40, 1'b1, -1, 0, 1'b1);
        tick();
        check_eq("restart valid", 32'(chunk_valid), 1);
        walk(8'd0, 1'b0, -1, 0, 1'b0);
        tick();
        check_quiet("final idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chunk_sequencer.md
# chunk_sequencer

Upstream address walker for the matrix-transpose engine. On a start command it visits every CHUNK_SIZE x CHUNK_SIZE tile of an ARR_SIZE x ARR_SIZE matrix in row-major tile order. For each tile it emits the tile's top-left byte address (`chunk_addr`) over a valid/ready handshake, and this output feeds `address_calc` directly. A one-cycle `done` pulse marks completion of the walk.

## Interface
- DATA_WIDTH, 32, element width in bits; byte stride per element = DATA_WIDTH/8
- ARR_SIZE, 8, matrix dimension in elements; must be a multiple of CHUNK_SIZE
- ADDR_WIDTH, 8, byte-address width
- CHUNK_SIZE, 2, tile edge in elements
- derived: NC = ARR_SIZE/CHUNK_SIZE; CW = max(1, $clog2(NC))

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a walk; sampled only in IDLE
- abort  in  1  synchronous cancel of the walk in progress
- base_addr  in  ADDR_WIDTH  matrix base byte address; latched when start is accepted
- chunk_ready  in  1  downstream accepts the current tile
- chunk_valid  out  1  chunk_addr, chunk_row, chunk_col and chunk_last are valid
- chunk_addr  out  ADDR_WIDTH  tile top-left byte address
- chunk_row  out  CW  tile row index, 0..NC-1
- chunk_col  out  CW  tile column index, 0..NC-1
- chunk_last  out  1  current tile is (NC-1, NC-1)
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the final tile handshake

## Operation
- States:
  - IDLE: outputs quiet.
  - ISSUE: presenting a tile.
  - DONE: done pulse for one cycle.
- IDLE -> ISSUE when start=1. On that edge:
  - latch base_addr;
  - clear row/col counters.
- chunk_addr = base_lat + (row*CHUNK_SIZE*ARR_SIZE + col*CHUNK_SIZE)*(DATA_WIDTH/8), truncated modulo 2^ADDR_WIDTH (wraps silently).
  - With the defaults, the column step is 8 and the row step is 64.
- The address is held in a register and updated incrementally: add the column step, or on a row wrap add the row step and subtract (NC-1)*column step. The result must equal the formula above.
- A handshake occurs when chunk_valid & chunk_ready.
  - On a handshake that is not the last tile: col increments; when col = NC-1, col wraps to 0 and row increments.
  - On the last-tile handshake: ISSUE -> DONE.
- DONE -> IDLE unconditionally after one cycle.
- In ISSUE, chunk_valid=1 and all payload outputs are stable until the handshake. No payload change while valid is high and ready is low.
- abort=1 in ISSUE: go to IDLE next edge, no done pulse. abort has priority over a coincident handshake.
- abort in IDLE or DONE: ignored.
- start outside IDLE: ignored; base_addr changes outside IDLE have no effect.
- start and abort both high in IDLE: start wins (abort is ignored in IDLE).

## Timing
- Reset values: state IDLE; chunk_valid=0, chunk_addr=0, chunk_row=0, chunk_col=0, chunk_last=0, busy=0, done=0.
- Start latency:
  - start sampled at edge N;
  - chunk_valid=1 with tile (0,0) from after edge N until the handshake;
  - busy rises in the same cycle.
- Throughput: one tile per cycle while chunk_ready is held high.
  - With ready=1 throughout, NC² tiles occupy NC² consecutive cycles.
  - done is high in the following cycle (cycle NC²+1 after the start edge).
  - busy is low the cycle after that.
- chunk_last is a registered output, coincident with the last tile's valid.
- rst asserted at any time, including mid-walk or during DONE: all outputs go to reset values immediately. No done pulse. After release, the block waits in IDLE for a new start.
- Restart: start may be asserted in the cycle done is high. It is ignored, because the state is DONE. The earliest accepted start is in the IDLE cycle after done.

## Test plan
- Defaults, base_addr=0, ready=1:
  - chunk_addr sequence 0,8,16,24,64,72,80,88,128,136,144,152,192,200,208,216 on consecutive cycles;
  - chunk_last only on 216;
  - done one cycle after it; busy low the next cycle.
- Backpressure: ready dropped for 3 cycles while tile 5 (addr 72, row 1, col 1) is presented -> addr/row/col/last stay constant for all 4 valid cycles; sequence resumes at 80; total walk is 3 cycles longer.
- Wrap: base_addr=200 -> sequence 200,208,216,224,8,16,24,32,... (mod 256); base_addr changed to 0 mid-walk has no effect.
- Abort: abort asserted together with ready on tile 3 (addr 24) -> next cycle IDLE, valid=0, no done. A subsequent start restarts at tile (0,0).
- Reset mid-walk: rst pulsed asynchronously (between edges) during tile 9 -> all outputs 0 immediately. After release, start with base 64 -> first address 64.
- Spurious start: start held high through a whole walk -> exactly one walk with one done pulse; a second walk is accepted only in the IDLE cycle after done.
